// File: rtl/ring_arbiter.sv
// ---------------------------------------------------------------------------
// ring_arbiter
//   Round-robin arbiter sharing one resource between N requesters. A one-hot
//   priority pointer (the ring token) marks the requester with the highest
//   priority. A grant is held until the grantee releases it, either by
//   pulsing its done bit or by dropping its request. After a release the
//   pointer moves to the requester just past the grantee. At least one idle
//   cycle always separates two grants.
//
//   Optional feature (macro RING_ARB_TIMEOUT_EN): a grant watchdog. If a
//   grant is held for 2^TMO_W cycles without a release, it is revoked exactly
//   as if it had been released, and timeout pulses for one cycle. When the
//   macro is undefined, no counter is built and timeout is tied to 0.
//
// Parameters:
//   N      number of requesters (2..16)
//   TMO_W  watchdog counter width (used only with RING_ARB_TIMEOUT_EN)
//
// Ports:
//   clock     in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   req       in   [N]  request level per requester
//   done      in   [N]  release pulse; only the current grantee's bit counts
//   grant     out  [N]  registered one-hot grant, zero when idle
//   grant_id  out  [$clog2(N)] index of the current or most recent grantee
//   busy      out  high while a grant is active
//   ptr       out  [N]  registered one-hot priority pointer
//   timeout   out  one-cycle pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
//   state | meaning
//   IDLE  | no grant; arbitrate among req starting at ptr
//   GRANT | one requester holds the resource until release (or watchdog)
// ---------------------------------------------------------------------------
module ring_arbiter #(
  parameter int N     = 4,
  parameter int TMO_W = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic [N-1:0]         ptr,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("ring_arbiter: N must be in 2..16");
  end
  if (TMO_W < 1) begin : g_bad_tmo_w
    $error("ring_arbiter: TMO_W must be at least 1");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   gid_q,   gid_d;
  logic [N-1:0]    ptr_q,   ptr_d;

  // Arbitration signals
  logic [N-1:0]    mask_hi;
  logic [N-1:0]    req_hi;
  logic [N-1:0]    cand;
  logic [N-1:0]    win_oh;
  logic [IW-1:0]   win_idx;
  logic            release_hit;
  logic [N-1:0]    ptr_next;

  // Wrap-around search: first look at requests at or above the pointer; if
  // there are none, the lowest set request overall is the wrapped winner.
  // ptr is one-hot, so ptr-1 is a mask of all positions below it.
  always_comb begin
    mask_hi = ~(ptr_q - N'(1));
    req_hi  = req & mask_hi;
    cand    = (|req_hi) ? req_hi : req;
    win_oh  = cand & (~cand + N'(1));
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) begin
        win_idx = IW'(i);
      end
    end
  end

  // Grant is one-hot, so masking done/~req with it picks the grantee's bit
  // and ignores every other requester.
  assign release_hit = |(grant_q & (done | ~req));
  assign ptr_next    = {grant_q[N-2:0], grant_q[N-1]};

`ifdef RING_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
`ifdef RING_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = win_oh;
          gid_d   = win_idx;
          state_d = GRANT;
`ifdef RING_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (release_hit) begin
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end
`ifdef RING_ARB_TIMEOUT_EN
        else if (cnt_q == {TMO_W{1'b1}}) begin
          // Watchdog revocation behaves exactly like a release.
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= N'(1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RING_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant    = grant_q;
  assign grant_id = gid_q;
  assign busy     = |grant_q;
  assign ptr      = ptr_q;

endmodule
